// File: rtl/sequential_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module      : sequential_bin2bcd
// Description : Iterative shift-and-add-3 (double-dabble) binary to packed BCD
//               converter with a start/busy/done handshake. One conversion
//               takes one clock per input bit. Digit 0 (units) is in
//               o_w_bcd[3:0].
//               Optional feature macro: SEQUENTIAL_BIN2BCD_SIGNED_EN
//                 defined   -> i_w_bin is two's complement. Its magnitude is
//                              converted and o_w_sign reports the input MSB.
//                 undefined -> i_w_bin is unsigned and o_w_sign is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sequential_bin2bcd #(
  parameter int p_data_width = 16,
  parameter int p_digits     = 5
) (
  input  logic                      i_w_clk,
  input  logic                      i_w_reset,
  input  logic [p_data_width-1:0]   i_w_bin,
  input  logic                      i_w_start,
  output logic [4*p_digits-1:0]     o_w_bcd,
  output logic                      o_w_busy,
  output logic                      o_w_done,
  output logic                      o_w_sign
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_bcd_w = 4 * p_digits;
  localparam int c_cnt_w = $clog2(p_data_width + 1);

  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(p_data_width);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;

  // Binary shift register: its MSB feeds the scratch LSB on every shift.
  logic [p_data_width-1:0]   r_bin;
  logic [p_data_width-1:0]   w_bin_nxt;

  // BCD scratch register. It is never exposed directly on the outputs.
  logic [c_bcd_w-1:0]        r_scratch;
  logic [c_bcd_w-1:0]        w_scratch_nxt;

  // Number of shifts still to perform.
  logic [c_cnt_w-1:0]        r_count;
  logic [c_cnt_w-1:0]        w_count_nxt;

  // Output result and completion pulse.
  logic [c_bcd_w-1:0]        r_bcd;
  logic [c_bcd_w-1:0]        w_bcd_nxt;
  logic                      r_done;
  logic                      w_done_nxt;

  // Value loaded into the shift register on an accepted start.
  logic [p_data_width-1:0]   w_load_val;

  // Scratch after the add-3 correction, and after the following shift.
  logic [c_bcd_w-1:0]        w_adj;
  logic [c_bcd_w-1:0]        w_shifted;

  // --------------------------------------------------------------------------
  // Input conditioning: unsigned pass-through or two's complement magnitude
  // --------------------------------------------------------------------------
`ifdef SEQUENTIAL_BIN2BCD_SIGNED_EN
  localparam logic [p_data_width-1:0] c_one_bin = p_data_width'(1);

  logic w_load_sign;
  logic w_accept;
  logic w_complete;
  logic r_sign_lat;
  logic r_sign;

  // Negating the most negative value wraps back to itself, and that pattern
  // read as unsigned is exactly the correct magnitude (0x8000 -> 32768).
  assign w_load_sign = i_w_bin[p_data_width-1];
  assign w_load_val  = w_load_sign ? (~i_w_bin + c_one_bin) : i_w_bin;
  assign w_accept    = (r_state == ST_IDLE) && i_w_start;
  assign w_complete  = w_done_nxt;

  // Sign is captured with the operand and published together with the result.
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      r_sign_lat <= 1'b0;
      r_sign     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sign_lat <= w_load_sign;
      end
      if (w_complete) begin
        r_sign <= r_sign_lat;
      end
    end
  end

  assign o_w_sign = r_sign;
`else
  assign w_load_val = i_w_bin;
  assign o_w_sign   = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Per-digit add-3 correction (4-bit add, no carry between digits)
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < p_digits; gi++) begin : g_digit
      assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5)
                              ? (r_scratch[4*gi +: 4] + 4'd3)
                              : r_scratch[4*gi +: 4];
    end
  endgenerate

  // Left shift of {scratch, binary}. The bit falling off the top digit is
  // always zero for a legal digit count, so truncation is safe.
  assign w_shifted = c_bcd_w'({w_adj, r_bin[p_data_width-1]});

  // --------------------------------------------------------------------------
  // Next-state and datapath decode
  // --------------------------------------------------------------------------
  // Decides state transitions and the next value of every datapath register.
  always_comb begin
    w_state_nxt   = r_state;
    w_bin_nxt     = r_bin;
    w_scratch_nxt = r_scratch;
    w_count_nxt   = r_count;
    w_bcd_nxt     = r_bcd;
    w_done_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // A start in the done cycle lands here, so back-to-back requests
        // are accepted without a bubble.
        if (i_w_start) begin
          w_state_nxt   = ST_SHIFT;
          w_bin_nxt     = w_load_val;
          w_scratch_nxt = '0;
          w_count_nxt   = c_cnt_load;
        end
      end

      ST_SHIFT: begin
        // Starts are ignored here and not remembered.
        w_bin_nxt     = r_bin << 1;
        w_scratch_nxt = w_shifted;
        w_count_nxt   = r_count - c_cnt_one;
        if (r_count == c_cnt_one) begin
          w_state_nxt = ST_IDLE;
          w_bcd_nxt   = w_shifted;
          w_done_nxt  = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  // Reset has priority over start and aborts a conversion without a done.
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      r_state   <= ST_IDLE;
      r_bin     <= '0;
      r_scratch <= '0;
      r_count   <= '0;
      r_bcd     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bin     <= w_bin_nxt;
      r_scratch <= w_scratch_nxt;
      r_count   <= w_count_nxt;
      r_bcd     <= w_bcd_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_w_bcd  = r_bcd;
  assign o_w_busy = (r_state == ST_SHIFT);
  assign o_w_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sequential_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_sequential_bin2bcd
// Description : Randomized scoreboard bench for sequential_bin2bcd. A
//               behavioural model predicts acceptance, busy, done and the
//               converted value with plain decimal arithmetic, and a monitor
//               compares the DUT against it on every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sequential_bin2bcd;

  localparam int W = 16;
  localparam int D = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   bin;
  logic [4*D-1:0] bcd;
  logic           busy;
  logic           done;
  logic           sign;

  sequential_bin2bcd #(
    .p_data_width (W),
    .p_digits     (D)
  ) dut (
    .i_w_clk   (clk),
    .i_w_reset (rst),
    .i_w_bin   (bin),
    .i_w_start (start),
    .o_w_bcd   (bcd),
    .o_w_busy  (busy),
    .o_w_done  (done),
    .o_w_sign  (sign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4*D-1:0] bcd;
    logic           sign;
    int             due;
  } exp_t;

  exp_t           q[$];
  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;
  int             countdown = 0;
  logic [4*D-1:0] m_bcd = '0;
  logic           m_sign = 1'b0;
  logic           m_done = 1'b0;
  logic [4*D-1:0] pend_bcd = '0;
  logic           pend_sign = 1'b0;

  // Decimal digits by repeated division.
  function automatic logic [4*D-1:0] to_bcd(input longint unsigned v);
    logic [4*D-1:0] r;
    longint unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic longint unsigned magnitude(input logic [W-1:0] v);
`ifdef SEQUENTIAL_BIN2BCD_SIGNED_EN
    if (v[W-1]) return (longint'(1) << W) - longint'(v);
`endif
    return longint'(v);
  endfunction

  function automatic logic sign_of(input logic [W-1:0] v);
`ifdef SEQUENTIAL_BIN2BCD_SIGNED_EN
    return v[W-1];
`else
    return 1'b0 & v[0];
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: one conversion takes W edges after acceptance; requests
  // while converting are dropped; reset aborts everything.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      m_done = 1'b0;
      if (rst) begin
        countdown = 0;
        m_bcd     = '0;
        m_sign    = 1'b0;
        q.delete();
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          m_bcd  = pend_bcd;
          m_sign = pend_sign;
          m_done = 1'b1;
        end
      end else if (start) begin
        exp_t e;
        pend_bcd  = to_bcd(magnitude(bin));
        pend_sign = sign_of(bin);
        e.bcd     = pend_bcd;
        e.sign    = pend_sign;
        e.due     = cyc + W;
        q.push_back(e);
        countdown = W;
      end
    end
  end

  // Monitor: per-cycle handshake/output checks plus scoreboard pop on done.
  initial begin
    forever begin
      @(negedge clk);
      check("busy", 32'(busy), 32'(countdown > 0));
      check("done", 32'(done), 32'(m_done));
      check("bcd_held", 32'(bcd), 32'(m_bcd));
      check("sign_held", 32'(sign), 32'(m_sign));
      if (done) begin
        if (q.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("result", 32'(bcd), 32'(e.bcd));
          check("result_sign", 32'(sign), 32'(e.sign));
          check("latency", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  task automatic convert(input logic [W-1:0] v, input int gap);
    start = 1'b1;
    bin   = v;
    tick(1);
    start = 1'b0;
    bin   = W'($urandom);
    tick(W + gap);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Basic values, including the extremes.
    convert(16'd8, 0);
    convert(16'd65535, 1);
    convert(16'd0, 2);

    // Start while busy is ignored; held start through done converts again.
    start = 1'b1; bin = 16'd1234;
    tick(1);
    start = 1'b0; bin = W'($urandom);
    tick(4);
    start = 1'b1; bin = 16'd9999;
    tick(1);
    start = 1'b0; bin = W'($urandom);
    tick(8);
    start = 1'b1; bin = 16'd9999;
    tick(4);
    start = 1'b0; bin = W'($urandom);
    tick(W + 2);

    // Reset mid-conversion aborts without a done pulse.
    start = 1'b1; bin = 16'd4321;
    tick(1);
    start = 1'b0;
    tick(6);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    convert(16'd42, 0);

    // Values that differ between signed and unsigned builds.
    convert(16'hFFF8, 0);
    convert(16'h8000, 0);
    convert(16'h7FFF, 0);

    // Random operands, random gaps and random stray starts while busy.
    for (int n = 0; n < 40; n++) begin
      start = 1'b1;
      bin   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 99)) : W'($urandom);
      tick(1);
      for (int k = 0; k < W + int'($urandom_range(0, 3)); k++) begin
        start = ($urandom_range(0, 5) == 0);
        bin   = W'($urandom);
        tick(1);
      end
      start = 1'b0;
    end

    start = 1'b0;
    tick(W + 4);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
